// File: rtl/matrix_port_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_port_host_pkg
// Description : Shared types and derived constants for the matrix port host.
//               The constants are computed from the default matrix geometry:
//               8 rows x 16 columns, 4 elements per word, field order 3.
//               C_EW element width, C_WORDS words per matrix,
//               C_AW memory address width, C_WD_TIMEOUT watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_port_host_pkg;

    localparam int C_L     = 8;
    localparam int C_K     = 16;
    localparam int C_BLOCK = 4;
    localparam int C_M     = 3;

    localparam int C_EW    = $clog2(C_M);
    localparam int C_WORDS = C_L * C_K / C_BLOCK;
    localparam int C_AW    = $clog2(C_WORDS);

    localparam logic [15:0] C_WD_TIMEOUT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_KICK   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_port_host_out.sv
`default_nettype none
// ============================================================================
// Module      : mph_out_reg
// Description : One-entry valid/ready output stage for the DRAIN read path.
//               A read issued in cycle t returns data in cycle t+1; that word
//               is presented directly and is captured only if the sink stalls.
//               At most one word (in flight or held) exists at any time, so a
//               new read may issue whenever nothing is presented or the word
//               presented is being consumed this cycle.
// Ports       : clk, rst_n        - clock, async active-low reset
//               issue             - memory read issued this cycle
//               rd_data           - memory read data (valid cycle after issue)
//               can_issue         - a read issued now will have a slot
//               out_data/out_valid/out_ready - downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module mph_out_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue,
    input  logic [DW-1:0] rd_data,
    output logic          can_issue,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic          r_pend;
    logic          r_valid;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_pend <= issue;
            // Returning word not taken: park it so out_data stays stable.
            if (r_pend && !out_ready) begin
                r_valid <= 1'b1;
                r_data  <= rd_data;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        out_valid = r_valid | r_pend;
        out_data  = r_valid ? r_data : (r_pend ? rd_data : '0);
        can_issue = !out_valid || out_ready;
    end

endmodule
`default_nettype wire

// File: rtl/matrix_port_host.sv
`default_nettype none
// ============================================================================
// Module      : matrix_port_host
// Description : Loads a matrix word stream into systemizer memory, checks the
//               element format, starts the systemizer, waits (with watchdog)
//               for completion and streams the result memory back out.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               in_data/in_valid/in_ready     - input word stream
//               out_data/out_valid/out_ready  - output word stream
//               busy, result_ok, result_err   - status (results sticky)
//               mem_wr_*, mem_rd_*            - systemizer memory port
//               sys_start, sys_done, sys_fail - systemizer control
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_port_host
    import matrix_port_host_pkg::*;
#(
    parameter int L     = C_L,
    parameter int K     = C_K,
    parameter int BLOCK = C_BLOCK,
    parameter int M     = C_M
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BLOCK*C_EW-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [BLOCK*C_EW-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    result_ok,
    output logic                    result_err,
    output logic                    mem_wr_en,
    output logic [C_AW-1:0]         mem_wr_addr,
    output logic [BLOCK*C_EW-1:0]   mem_wr_data,
    output logic                    mem_rd_en,
    output logic [C_AW-1:0]         mem_rd_addr,
    input  logic [BLOCK*C_EW-1:0]   mem_rd_data,
    output logic                    sys_start,
    input  logic                    sys_done,
    input  logic                    sys_fail
);

    localparam logic [C_AW-1:0] C_LAST = C_AW'(L * K / BLOCK - 1);
    localparam logic [C_EW:0]   C_MV   = (C_EW + 1)'(M);

    state_t          r_state;
    state_t          w_next_state;
    logic [C_AW-1:0] r_wcnt;
    logic [C_AW-1:0] r_raddr;
    logic [C_AW-1:0] r_ocnt;
    logic            r_rd_all;
    logic [15:0]     r_wd;
    logic            r_fmt_err;
    logic            r_ok;
    logic            r_err;
    logic            w_accept;
    logic            w_rd_issue;
    logic            w_can_issue;
    logic            w_consume;
    logic            w_set_ok;
    logic            w_set_err;
    logic            w_bad;

    // Any element whose value is outside the field marks the run as bad.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            if ({1'b0, in_data[i*C_EW +: C_EW]} >= C_MV) begin
                w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        sys_start    = 1'b0;
        w_accept     = 1'b0;
        w_rd_issue   = 1'b0;
        w_set_ok     = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && (r_wcnt == C_LAST)) begin
                    w_next_state = ST_KICK;
                end
            end
            ST_KICK: begin
                if (r_fmt_err) begin
                    w_set_err    = 1'b1;
                    w_next_state = ST_FINISH;
                end else begin
                    sys_start    = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sys_done) begin
                    if (sys_fail) begin
                        w_set_err    = 1'b1;
                        w_next_state = ST_FINISH;
                    end else begin
                        w_set_ok     = 1'b1;
                        w_next_state = ST_DRAIN;
                    end
                end else if (r_wd == C_WD_TIMEOUT) begin
                    w_set_err    = 1'b1;
                    w_next_state = ST_FINISH;
                end
            end
            ST_DRAIN: begin
                w_rd_issue = !r_rd_all && w_can_issue;
                if (w_consume && (r_ocnt == C_LAST)) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt    <= '0;
            r_fmt_err <= 1'b0;
            r_wd      <= '0;
            r_raddr   <= '0;
            r_rd_all  <= 1'b0;
            r_ocnt    <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wcnt    <= (r_wcnt == C_LAST) ? '0 : r_wcnt + C_AW'(1);
                // First word of a run starts a fresh format check.
                r_fmt_err <= ((r_state == ST_IDLE) ? 1'b0 : r_fmt_err) | w_bad;
            end

            r_wd <= (r_state == ST_WAIT) ? r_wd + 16'd1 : 16'd0;

            if (r_state != ST_DRAIN) begin
                r_raddr  <= '0;
                r_rd_all <= 1'b0;
                r_ocnt   <= '0;
            end else begin
                if (w_rd_issue) begin
                    if (r_raddr == C_LAST) begin
                        r_rd_all <= 1'b1;
                    end else begin
                        r_raddr <= r_raddr + C_AW'(1);
                    end
                end
                if (w_consume) begin
                    r_ocnt <= r_ocnt + C_AW'(1);
                end
            end

            if ((r_state == ST_IDLE) && in_valid) begin
                r_ok  <= 1'b0;
                r_err <= 1'b0;
            end else begin
                if (w_set_ok) begin
                    r_ok <= 1'b1;
                end
                if (w_set_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    mph_out_reg #(
        .DW(BLOCK * C_EW)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (w_rd_issue),
        .rd_data   (mem_rd_data),
        .can_issue (w_can_issue),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign w_consume   = out_valid & out_ready;
    assign busy        = (r_state != ST_IDLE);
    assign result_ok   = r_ok;
    assign result_err  = r_err;
    assign mem_wr_en   = w_accept;
    assign mem_wr_addr = r_wcnt;
    assign mem_wr_data = in_data;
    assign mem_rd_en   = w_rd_issue;
    assign mem_rd_addr = r_raddr;

endmodule
`default_nettype wire

// File: tb/tb_matrix_port_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_port_host
// Description : Self-checking bench for matrix_port_host. Stimulus pushes the
//               expected output words into a queue; an independent monitor
//               pops and compares on every output handshake. Includes a
//               memory model and a systemizer model (done / fail / silent).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_port_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       result_ok;
    logic       result_err;
    logic       mem_wr_en;
    logic [4:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic       mem_rd_en;
    logic [4:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic       sys_start;
    logic       sys_done = 1'b0;
    logic       sys_fail = 1'b0;

    matrix_port_host u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .result_ok   (result_ok),
        .result_err  (result_err),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .sys_start   (sys_start),
        .sys_done    (sys_done),
        .sys_fail    (sys_fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, overlap_cnt = 0, recv_cnt = 0, start_cnt = 0;
    int start_cyc = 0, first_v = -1, last_cons = 0, last_acc = 0;
    int sys_mode = 0;       // 0: done ok after 10 cycles, 1: done+fail, 2: silent
    bit rnd_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] mem [0:31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Index written as four base-3 digits: no element can ever be 2'b11.
    // 0->00, 1->01, 2->02, 3->04, 4->05, 9->10, 27->40, 31->45
    function automatic logic [7:0] tri3(input int i);
        return {2'(i / 27), 2'((i / 9) % 3), 2'((i / 3) % 3), 2'(i % 3)};
    endfunction

    function automatic logic [7:0] word_of(input int kind, input int i);
        if (kind == 1 && i == 5) return 8'hC0;
        if (kind == 2) return tri3(31 - i);
        return tri3(i);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_wr_en) wr_cnt++;
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en && mem_rd_en) overlap_cnt++;
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && out_ready) begin
                recv_cnt++;
                last_cons = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_extra: got word %0h expected none", out_data);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Systemizer model.
    initial begin
        forever begin
            @(negedge clk);
            if (sys_start) begin
                start_cnt++;
                start_cyc = cyc;
                @(negedge clk);
                chk("start_pulse_len", 32'(sys_start), 32'd0);
                if (sys_mode != 2) begin
                    repeat (9) @(posedge clk);
                    #1;
                    sys_done = 1'b1;
                    sys_fail = (sys_mode == 1);
                    @(posedge clk);
                    #1;
                    sys_done = 1'b0;
                    sys_fail = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic load_words(input int kind, input int nwords, input bit push_exp);
        for (int i = 0; i < nwords; i++) begin
            in_valid = 1'b1;
            in_data  = word_of(kind, i);
            if (push_exp) exp_q.push_back(word_of(kind, i));
            @(posedge clk);
            #1;
            if (i == 0) begin
                chk("flags_clear_ok", 32'(result_ok), 32'd0);
                chk("flags_clear_err", 32'(result_err), 32'd0);
            end
        end
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    int s_start, s_recv, s_rd, s_wr;

    task automatic snap();
        s_start = start_cnt;
        s_recv  = recv_cnt;
        s_rd    = rd_cnt;
        s_wr    = wr_cnt;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_result", {30'd0, result_ok, result_err}, 32'd0);
        chk("rst_strobes", {29'd0, sys_start, mem_wr_en, mem_rd_en}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // sys_done while idle must be ignored.
        sys_done = 1'b1;
        @(posedge clk);
        #1;
        sys_done = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_done_busy", 32'(busy), 32'd0);
        chk("idle_done_ok", 32'(result_ok), 32'd0);

        // Good run, sink always ready.
        sys_mode = 0;
        snap();
        first_v = -1;
        load_words(0, 32, 1'b1);
        wait_idle("ok_run", 2000);
        chk("ok_starts", 32'(start_cnt - s_start), 32'd1);
        chk("ok_writes", 32'(wr_cnt - s_wr), 32'd32);
        chk("ok_recv", 32'(recv_cnt - s_recv), 32'd32);
        chk("ok_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("ok_rate", 32'(last_cons - first_v), 32'd31);
        chk("ok_result_ok", 32'(result_ok), 32'd1);
        chk("ok_result_err", 32'(result_err), 32'd0);

        // Format error in word 5.
        snap();
        load_words(1, 32, 1'b0);
        wait_idle("fmt", 100);
        chk("fmt_busy_drop", 32'(cyc - last_acc), 32'd2);
        chk("fmt_starts", 32'(start_cnt - s_start), 32'd0);
        chk("fmt_writes", 32'(wr_cnt - s_wr), 32'd32);
        chk("fmt_reads", 32'(rd_cnt - s_rd), 32'd0);
        chk("fmt_result_err", 32'(result_err), 32'd1);
        chk("fmt_result_ok", 32'(result_ok), 32'd0);

        // Systemizer reports failure.
        sys_mode = 1;
        snap();
        load_words(0, 32, 1'b0);
        wait_idle("fail", 200);
        chk("fail_starts", 32'(start_cnt - s_start), 32'd1);
        chk("fail_reads", 32'(rd_cnt - s_rd), 32'd0);
        chk("fail_recv", 32'(recv_cnt - s_recv), 32'd0);
        chk("fail_result_err", 32'(result_err), 32'd1);
        chk("fail_result_ok", 32'(result_ok), 32'd0);

        // Good run with a randomly stalling sink.
        sys_mode = 0;
        snap();
        rnd_ready = 1'b1;
        load_words(2, 32, 1'b1);
        wait_idle("rnd", 2000);
        rnd_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        chk("rnd_recv", 32'(recv_cnt - s_recv), 32'd32);
        chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rnd_result_ok", 32'(result_ok), 32'd1);

        // Reset in the middle of a load, then a full fresh run.
        load_words(0, 17, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap();
        load_words(2, 32, 1'b1);
        wait_idle("midrst", 2000);
        chk("midrst_recv", 32'(recv_cnt - s_recv), 32'd32);
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("midrst_result_ok", 32'(result_ok), 32'd1);

        // Silent systemizer: watchdog.
        sys_mode = 2;
        snap();
        load_words(0, 32, 1'b0);
        begin
            int n = 0;
            while (!result_err && n < 70000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("wd_result_err", 32'(result_err), 32'd1);
        // Error is visible after the edge 65536 edges past the one sampling sys_start.
        chk("wd_cycles", 32'(cyc - start_cyc), 32'd65537);
        wait_idle("wd", 100);
        chk("wd_reads", 32'(rd_cnt - s_rd), 32'd0);
        chk("wd_result_ok", 32'(result_ok), 32'd0);

        chk("rw_overlap", 32'(overlap_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
